// File: rtl/ps2_key_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder_if
//   Pop handshake between the ps2_keyboard scan-code FIFO and its consumer.
//   ps2_data      head byte of the FIFO, valid while ps2_ready=1
//   ps2_ready     FIFO non-empty
//   ps2_overflow  FIFO overflowed (sticky in the source)
//   nextdata_n    active-low pop strobe from the consumer
//   master: FIFO side, slave: decoder side.
// ----------------------------------------------------------------------------
interface ps2_key_decoder_if;
   logic [7:0] ps2_data;
   logic       ps2_ready;
   logic       ps2_overflow;
   logic       nextdata_n;

   modport master (
      output ps2_data,
      output ps2_ready,
      output ps2_overflow,
      input  nextdata_n
   );

   modport slave (
      input  ps2_data,
      input  ps2_ready,
      input  ps2_overflow,
      output nextdata_n
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//   Pops Set-2 scan-code bytes from the ps2_keyboard FIFO and turns them into
//   key events (single held-key tracking, E0/F0 prefix parsing).
//   clk, rst     clock (posedge) and asynchronous active-high reset
//   fifo         slave side of the FIFO pop handshake
//   key_code     last make code (without prefix)
//   key_ext      key_code came with an E0 prefix
//   key_ascii    lowercase ASCII of key_code, 8'h00 if unmapped or extended
//   key_down     a key is currently held
//   key_event    one-cycle pulse on new press or release
//   key_repeat   one-cycle pulse on typematic repeat of the held key
//   press_cnt    distinct presses since reset, wraps modulo 2**CNT_W
//   ovf_seen     sticky: ps2_overflow was observed high
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int unsigned CNT_W    = 8,
   parameter bit          ASCII_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   ps2_key_decoder_if.slave   fifo,
   output logic [7:0]         key_code,
   output logic               key_ext,
   output logic [7:0]         key_ascii,
   output logic               key_down,
   output logic               key_event,
   output logic               key_repeat,
   output logic [CNT_W-1:0]   press_cnt,
   output logic               ovf_seen
);

   typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

   state_t     state;
   logic [7:0] byte_r;
   logic       ext_p;
   logic       brk_p;
   logic       held_match;
   logic [7:0] rom_ascii;

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
         8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
         8'h3E: a = 8'h38; 8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   always_comb begin
      rom_ascii = '0;
      if (ASCII_EN) rom_ascii = scan_to_ascii(byte_r);
   end

   // The byte refers to the key we already track (same prefix and code).
   always_comb begin
      held_match = key_down && ({ext_p, byte_r} == {key_ext, key_code});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         byte_r          <= '0;
         ext_p           <= 1'b0;
         brk_p           <= 1'b0;
         fifo.nextdata_n <= 1'b1;
         key_code        <= '0;
         key_ext         <= 1'b0;
         key_ascii       <= '0;
         key_down        <= 1'b0;
         key_event       <= 1'b0;
         key_repeat      <= 1'b0;
         press_cnt       <= '0;
         ovf_seen        <= 1'b0;
      end else begin
         key_event  <= 1'b0;
         key_repeat <= 1'b0;
         ovf_seen   <= ovf_seen | fifo.ps2_overflow;
         case (state)
            IDLE: begin
               if (fifo.ps2_ready) begin
                  byte_r          <= fifo.ps2_data;
                  fifo.nextdata_n <= 1'b0;
                  state           <= POP;
               end
            end
            POP: begin
               fifo.nextdata_n <= 1'b1;
               state           <= GAP;
               if (byte_r == 8'hE0) begin
                  ext_p <= 1'b1;
               end else if (byte_r == 8'hF0) begin
                  brk_p <= 1'b1;
               end else begin
                  ext_p <= 1'b0;
                  brk_p <= 1'b0;
                  if (brk_p) begin
                     // Releases of keys other than the tracked one are dropped.
                     if (held_match) begin
                        key_down  <= 1'b0;
                        key_event <= 1'b1;
                     end
                  end else if (held_match) begin
                     key_repeat <= 1'b1;
                  end else begin
                     key_code  <= byte_r;
                     key_ext   <= ext_p;
                     key_ascii <= ext_p ? 8'h00 : rom_ascii;
                     key_down  <= 1'b1;
                     press_cnt <= press_cnt + 1'b1;
                     key_event <= 1'b1;
                  end
               end
            end
            // Source is updating its read pointer; ps2_ready is not trusted here.
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder with a small FIFO model on the
//   master side of the pop handshake.
// ----------------------------------------------------------------------------
module tb_ps2_key_decoder;

   logic       clk;
   logic       rst;
   logic       ovf;
   logic [7:0] key_code;
   logic       key_ext;
   logic [7:0] key_ascii;
   logic       key_down;
   logic       key_event;
   logic       key_repeat;
   logic [7:0] press_cnt;
   logic       ovf_seen;

   int errors = 0;
   int checks = 0;

   // FIFO model: writer is the stimulus process, reader is the pop process.
   logic [7:0] fifo_mem [0:15];
   logic [4:0] wr_ptr = '0;
   logic [4:0] rd_ptr = '0;

   ps2_key_decoder_if bus ();

   assign bus.ps2_data     = fifo_mem[rd_ptr[3:0]];
   assign bus.ps2_ready    = (wr_ptr != rd_ptr);
   assign bus.ps2_overflow = ovf;

   ps2_key_decoder #(.CNT_W(8), .ASCII_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo       (bus),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_ascii  (key_ascii),
      .key_down   (key_down),
      .key_event  (key_event),
      .key_repeat (key_repeat),
      .press_cnt  (press_cnt),
      .ovf_seen   (ovf_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!bus.nextdata_n && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 5'd1;
   end

   // Monitor counters, sampled on the inactive edge.
   int cyc      = 0;
   int ev_cnt   = 0;
   int rep_cnt  = 0;
   int low_cnt  = 0;
   int wide_cnt = 0;
   int gap_bad  = 0;
   int last_low = 0;
   bit have_last = 1'b0;
   bit prev_low  = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (key_event === 1'b1)  ev_cnt  <= ev_cnt + 1;
      if (key_repeat === 1'b1) rep_cnt <= rep_cnt + 1;
      if (bus.nextdata_n === 1'b0) begin
         low_cnt <= low_cnt + 1;
         if (prev_low) wide_cnt <= wide_cnt + 1;
         if (have_last && (cyc - last_low) < 3) gap_bad <= gap_bad + 1;
         last_low  <= cyc;
         have_last <= 1'b1;
      end
      prev_low <= (bus.nextdata_n === 1'b0);
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[3:0]] = b;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((rd_ptr != wr_ptr) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rd_ptr != wr_ptr) begin
         errors++;
         $display("FAIL %s_drain: fifo still holds %0d bytes, required 0", name, wr_ptr - rd_ptr);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input string name);
      @(negedge clk);
      push(b);
      wait_drain(name);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b, required 1", bus.nextdata_n); end
      checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL rst_key_code: got %h, required 00", key_code); end
      checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL rst_key_down: got %b, required 0", key_down); end
      checks++; if (press_cnt !== 8'h00) begin errors++; $display("FAIL rst_press_cnt: got %h, required 00", press_cnt); end
      checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL rst_ovf_seen: got %b, required 0", ovf_seen); end
   endtask

   task automatic test_press_release();
      int ev0;
      ev0 = ev_cnt;
      send(8'h1C, "t1_make");
      checks++; if (key_code !== 8'h1C) begin errors++; $display("FAIL t1_code: got %h, required 1c", key_code); end
      checks++; if (key_ascii !== 8'h61) begin errors++; $display("FAIL t1_ascii: got %h, required 61", key_ascii); end
      checks++; if (press_cnt !== 8'h01) begin errors++; $display("FAIL t1_cnt: got %h, required 01", press_cnt); end
      checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL t1_down_press: got %b, required 1", key_down); end
      send(8'hF0, "t1_brk");
      send(8'h1C, "t1_rel");
      checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL t1_down_release: got %b, required 0", key_down); end
      checks++; if (ev_cnt - ev0 !== 2) begin errors++; $display("FAIL t1_events: got %0d, required 2", ev_cnt - ev0); end
   endtask

   task automatic test_typematic();
      int ev0, rp0;
      do_reset();
      ev0 = ev_cnt;
      rp0 = rep_cnt;
      send(8'h1C, "t2_a");
      send(8'h1C, "t2_b");
      send(8'h1C, "t2_c");
      checks++; if (press_cnt !== 8'h01) begin errors++; $display("FAIL t2_cnt: got %h, required 01", press_cnt); end
      checks++; if (rep_cnt - rp0 !== 2) begin errors++; $display("FAIL t2_repeats: got %0d, required 2", rep_cnt - rp0); end
      checks++; if (ev_cnt - ev0 !== 1) begin errors++; $display("FAIL t2_events: got %0d, required 1", ev_cnt - ev0); end
      send(8'hF0, "t2_brk");
      send(8'h1C, "t2_rel");
   endtask

   task automatic test_extended();
      send(8'hE0, "t3_e0");
      send(8'h75, "t3_make");
      checks++; if (key_ext !== 1'b1) begin errors++; $display("FAIL t3_ext: got %b, required 1", key_ext); end
      checks++; if (key_code !== 8'h75) begin errors++; $display("FAIL t3_code: got %h, required 75", key_code); end
      checks++; if (key_ascii !== 8'h00) begin errors++; $display("FAIL t3_ascii: got %h, required 00", key_ascii); end
      checks++; if (press_cnt !== 8'h02) begin errors++; $display("FAIL t3_cnt: got %h, required 02", press_cnt); end
      // Non-extended release of 75 is a different key and must be ignored.
      send(8'hF0, "t3_brk_plain");
      send(8'h75, "t3_rel_plain");
      checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL t3_plain_release: got %b, required 1", key_down); end
      send(8'hE0, "t3_e0b");
      send(8'hF0, "t3_brk");
      send(8'h75, "t3_rel");
      checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL t3_down_release: got %b, required 0", key_down); end
   endtask

   task automatic test_back_to_back();
      int l0, w0, g0, ev0;
      @(negedge clk);
      l0 = low_cnt; w0 = wide_cnt; g0 = gap_bad; ev0 = ev_cnt;
      push(8'h1C); push(8'hF0); push(8'h1C); push(8'h32);
      wait_drain("t4");
      checks++; if (low_cnt - l0 !== 4) begin errors++; $display("FAIL t4_pops: got %0d, required 4", low_cnt - l0); end
      checks++; if (wide_cnt - w0 !== 0) begin errors++; $display("FAIL t4_wide_pops: got %0d, required 0", wide_cnt - w0); end
      checks++; if (gap_bad - g0 !== 0) begin errors++; $display("FAIL t4_pop_spacing: got %0d close pops, required 0", gap_bad - g0); end
      checks++; if (ev_cnt - ev0 !== 3) begin errors++; $display("FAIL t4_events: got %0d, required 3", ev_cnt - ev0); end
      checks++; if (key_code !== 8'h32) begin errors++; $display("FAIL t4_code: got %h, required 32", key_code); end
      checks++; if (key_ascii !== 8'h62) begin errors++; $display("FAIL t4_ascii: got %h, required 62", key_ascii); end
      checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL t4_down: got %b, required 1", key_down); end
   endtask

   task automatic test_wrap_and_reset();
      int n;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send((i % 2 == 0) ? 8'h16 : 8'h1E, "t5_press");
         if (i == 254) begin
            checks++; if (press_cnt !== 8'hFF) begin errors++; $display("FAIL t5_cnt_max: got %h, required ff", press_cnt); end
         end
      end
      checks++; if (press_cnt !== 8'h00) begin errors++; $display("FAIL t5_cnt_wrap: got %h, required 00", press_cnt); end
      checks++; if (key_ascii !== 8'h32) begin errors++; $display("FAIL t5_ascii: got %h, required 32", key_ascii); end
      // Reset while the pop strobe is low.
      @(negedge clk);
      push(8'h16);
      n = 0;
      while ((bus.nextdata_n !== 1'b0) && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.nextdata_n !== 1'b0) begin errors++; $display("FAIL t5_pop_seen: got %b, required 0", bus.nextdata_n); end
      #1 rst = 1'b1;
      #1;
      checks++; if (bus.nextdata_n !== 1'b1) begin errors++; $display("FAIL t5_async_nextdata_n: got %b, required 1", bus.nextdata_n); end
      checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL t5_async_down: got %b, required 0", key_down); end
      @(negedge clk);
      rst = 1'b0;
      wait_drain("t5_after_rst");
      checks++; if (press_cnt !== 8'h01) begin errors++; $display("FAIL t5_cnt_after_rst: got %h, required 01", press_cnt); end
      checks++; if (key_ascii !== 8'h31) begin errors++; $display("FAIL t5_ascii_after_rst: got %h, required 31", key_ascii); end
   endtask

   task automatic test_overflow();
      checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL t6_ovf_before: got %b, required 0", ovf_seen); end
      @(negedge clk);
      ovf = 1'b1;
      @(negedge clk);
      ovf = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (ovf_seen !== 1'b1) begin errors++; $display("FAIL t6_ovf_sticky: got %b, required 1", ovf_seen); end
      do_reset();
      checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL t6_ovf_cleared: got %b, required 0", ovf_seen); end
   endtask

   initial begin
      rst = 1'b1;
      ovf = 1'b0;
      for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;
      test_reset();
      test_press_release();
      test_typematic();
      test_extended();
      test_back_to_back();
      test_wrap_and_reset();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
